// File: rtl/if_else_segment_scheduler.sv
// ---------------------------------------------------------------------------
// if_else_segment_scheduler
//
// Purpose:
//   Shares one pipelined if/else combine unit across NUM_SEG segments. On an
//   accepted start, the condition operand and both operand arrays are
//   latched. One segment per cycle is then issued to the unit. Each result
//   that comes back is written into that segment's result register. A single
//   instance of this block therefore replaces NUM_SEG copies of the unit.
//
// Parameters:
//   WIDTH   - width of every operand and result
//   NUM_SEG - segments sequenced per run (2..16)
//   LAT     - fixed issue-to-result latency of the shared unit (1..8)
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset, highest priority
//   start            in   one-cycle run request, only honoured when idle
//   input_bit        in   condition operand, latched at accepted start
//   array_ref_wire   in   if-operands, segment k at [k*WIDTH +: WIDTH]
//   array_ref_m_wire in   else-operands, same packing
//   unit_valid       out  issue strobe to the shared unit
//   unit_input_bit   out  latched condition operand
//   unit_ref         out  if-operand of the segment being issued
//   unit_ref_m       out  else-operand of the segment being issued
//   unit_result      in   unit output, valid LAT cycles after unit_valid
//   busy             out  run in progress (ISSUE or DRAIN)
//   done             out  one-cycle pulse once every segment is captured
//   segment_combine  out  per-segment results, same packing as operands
//
// Optional feature (macro IF_ELSE_SCHED_PERF_EN):
//   Adds output run_cycles[15:0]. It counts busy cycles of the current or
//   most recent run. It is cleared at accepted start and saturates at 16'hFFFF.
// ---------------------------------------------------------------------------
module if_else_segment_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NUM_SEG = 4,
  parameter int LAT     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           input_bit,
  input  logic [NUM_SEG*WIDTH-1:0]   array_ref_wire,
  input  logic [NUM_SEG*WIDTH-1:0]   array_ref_m_wire,
  output logic                       unit_valid,
  output logic [WIDTH-1:0]           unit_input_bit,
  output logic [WIDTH-1:0]           unit_ref,
  output logic [WIDTH-1:0]           unit_ref_m,
  input  logic [WIDTH-1:0]           unit_result,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_SEG*WIDTH-1:0]   segment_combine
`ifdef IF_ELSE_SCHED_PERF_EN
  ,
  output logic [15:0]                run_cycles
`endif
);

  localparam int IDXW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SEG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [IDXW-1:0] idx_reg, idx_next;

  logic accept;
  logic issue;
  logic pending;

  // Operand copies taken at accepted start; the wires are free afterwards.
  logic [WIDTH-1:0]         cond_lat_reg;
  logic [NUM_SEG*WIDTH-1:0] ref_lat_reg;
  logic [NUM_SEG*WIDTH-1:0] ref_m_lat_reg;

  logic [WIDTH-1:0] ref_slot   [NUM_SEG];
  logic [WIDTH-1:0] ref_m_slot [NUM_SEG];

  // In-flight tracker: stage LAT-1 lines up with unit_result.
  logic            fl_valid_reg [LAT];
  logic [IDXW-1:0] fl_idx_reg   [LAT];
  logic            emerge_valid;
  logic [IDXW-1:0] emerge_idx;

  assign emerge_valid = fl_valid_reg[LAT-1];
  assign emerge_idx   = fl_idx_reg[LAT-1];

  // Only entries that are still behind the emerging one count as pending.
  // The emerging entry is captured on this same edge, so DONE follows
  // right after the last capture.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      pending = pending | fl_valid_reg[i];
    end
  end

  // ---------------- FSM next-state / outputs ----------------
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          idx_next   = '0;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = S_DRAIN;
        end else begin
          idx_next = idx_reg + IDXW'(1);
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!pending) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------- FSM state register and operand latches ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      idx_reg       <= '0;
      cond_lat_reg  <= '0;
      ref_lat_reg   <= '0;
      ref_m_lat_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (accept) begin
        cond_lat_reg  <= input_bit;
        ref_lat_reg   <= array_ref_wire;
        ref_m_lat_reg <= array_ref_m_wire;
      end
    end
  end

  // ---------------- in-flight shift register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        fl_valid_reg[i] <= 1'b0;
        fl_idx_reg[i]   <= '0;
      end
    end else begin
      fl_valid_reg[0] <= issue;
      fl_idx_reg[0]   <= idx_reg;
      for (int i = 1; i < LAT; i++) begin
        fl_valid_reg[i] <= fl_valid_reg[i-1];
        fl_idx_reg[i]   <= fl_idx_reg[i-1];
      end
    end
  end

  // ---------------- per-segment slices and result registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      logic [WIDTH-1:0] slot_reg;

      assign ref_slot[gi]   = ref_lat_reg[gi*WIDTH +: WIDTH];
      assign ref_m_slot[gi] = ref_m_lat_reg[gi*WIDTH +: WIDTH];

      // A slot changes only when its own tracker entry emerges. Untouched
      // slots keep the previous run's value.
      always_ff @(posedge clk) begin
        if (reset) begin
          slot_reg <= '0;
        end else if (emerge_valid && (emerge_idx == IDXW'(gi))) begin
          slot_reg <= unit_result;
        end
      end

      assign segment_combine[gi*WIDTH +: WIDTH] = slot_reg;
    end
  endgenerate

  assign unit_valid     = issue;
  assign unit_input_bit = cond_lat_reg;
  assign unit_ref       = ref_slot[idx_reg];
  assign unit_ref_m     = ref_m_slot[idx_reg];

`ifdef IF_ELSE_SCHED_PERF_EN
  logic [15:0] run_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cycles_reg <= '0;
    end else if (accept) begin
      run_cycles_reg <= '0;
    end else if (busy && (run_cycles_reg != 16'hFFFF)) begin
      run_cycles_reg <= run_cycles_reg + 16'd1;
    end
  end

  assign run_cycles = run_cycles_reg;
`endif

endmodule
